logic_unit_arbiter: RTL and testbench
=====================================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares the pipelined 32-bit logic unit between two requesters (req0, req1).
//  Arbitrates round-robin, issues one op per cycle into the LU and tags each op in flight.
//  Routes every LU result back to the requester that issued it; provides flush and drain control.
//  Sits between the decode/issue stage (req0) and the writeback-side helper port (req1) and the LU.
// PARAMETERS
//  W       32  operand/result width
//  LU_LAT  3   cycles from LU input sample to valid lu_out (fixed LU pipeline depth); >=1
//  CW      2   inflight counter width, must satisfy 2^CW > LU_LAT
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   synchronous reset, active low
//  req0_valid   in   1   requester 0 has an op
//  req0_ready   out  1   requester 0 op accepted this cycle (valid&ready = transfer)
//  req0_a/_b    in   W   requester 0 operands
//  req0_op      in   3   requester 0 LU opcode
//  req1_*       ---  --  identical set for requester 1
//  resp0_valid  out  1   resp_data belongs to requester 0 this cycle
//  resp1_valid  out  1   resp_data belongs to requester 1 this cycle
//  resp_data    out  W   result (= lu_out), shared by both requesters
//  lu_a/lu_b    out  W   operands to LU
//  lu_op        out  3   opcode to LU
//  lu_out       in   W   LU result
//  flush        in   1   kill all in-flight ops, block issue this cycle
//  drain_req    in   1   stop issuing and wait for empty pipeline
//  drain_ack    out  1   pipeline empty while in HALTED
//  inflight0/1  out  CW  ops in flight per requester
//  busy         out  1   any op in flight
// BEHAVIOUR
//  Reset (rst_n=0 at edge): tags cleared, inflight=0, last_grant=1 (req0 wins first), FSM=RUN.
//   All outputs 0 while rst_n=0 (ready, resp_valid, busy, drain_ack, lu_*).
//  FSM: RUN -(drain_req)-> DRAIN -(busy==0)-> HALTED -(!drain_req)-> RUN.
//   DRAIN with drain_req dropped -> RUN. RUN with drain_req and busy==0 -> DRAIN for 1 cycle -> HALTED.
//  Grant (RUN only, flush=0): one valid -> that one; both valid -> the one != last_grant.
//   reqX_ready = grant==X, combinational; no ready without valid.
//   last_grant updates only on transfer.
//  Issue: lu_a/lu_b/lu_op driven combinationally from granted requester; zeros when no grant.
//  Tag pipe: LU_LAT stages of {v,id}; stage0 <= {transfer, grant_id}; shifts every cycle.
//  Response: respX_valid = tag[LU_LAT-1].v & id==X & !flush; resp_data = lu_out always.
//   One response per cycle max; no backpressure on responses.
//  Flush: all tag v cleared at the edge; no transfer that cycle; inflight0/1 <= 0.
//  Inflight: +1 on issue, -1 on retire, unchanged on both same cycle; never wraps (CW sized).
//  busy = OR of all tag v (registered state). drain_ack = (state==HALTED).
//  Reset mid-operation: all in-flight ops dropped, no response emitted afterwards.
// STRUCTURE
//  Shared header lu_defs.v: `define LU_LAT, LU opcode constants, FSM state encodings
//   (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2).
//  Sub-module lu_tag_pipe (LU_LAT-deep {v,id} shift register with sync clear);
//   arbiter, FSM and counters stay in the top.
// TESTING
//  T1 reset: rst_n=0 for 2 cycles with both valid -> readys 0, busy 0; first grant after reset to req0.
//  T2 contention: both valid continuously, ops 0..5 -> grants alternate 0,1,0,1,..; resp order 0,1,0,1,
//   each LU_LAT=3 cycles after its issue; resp_data matches LU model (a=32'hF0F0_F0F0, b=32'h0FF0_0FF0).
//  T3 single requester: only req1 valid 4 cycles -> 4 back-to-back grants to req1, inflight1 peaks at 3.
//  T4 flush: issue 3 ops, assert flush 1 cycle after third issue -> no resp*_valid for them, busy 0,
//   inflight 0 next cycle, no grant in flush cycle.
//  T5 drain: 2 ops in flight, drain_req=1 -> readys 0, both responses still delivered,
//   drain_ack=1 exactly 1 cycle after busy falls; drop drain_req -> RUN, grants resume next cycle.
//  T6 reset mid-flight: rst_n=0 one cycle with 3 ops pending -> no responses, counters 0.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types for the logic-unit arbiter: LU opcodes, FSM states, tags.
package logic_unit_arbiter_pkg;

    localparam int W_DEF      = 32;
    localparam int LU_LAT_DEF = 3;
    localparam int CW_DEF     = 2;

    typedef enum logic [2:0] {
        LU_AND  = 3'd0,
        LU_OR   = 3'd1,
        LU_XOR  = 3'd2,
        LU_NAND = 3'd3,
        LU_NOR  = 3'd4,
        LU_XNOR = 3'd5,
        LU_ANDN = 3'd6,
        LU_PASS = 3'd7
    } lu_op_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

endpackage

// File: rtl/logic_unit_arbiter_if.sv
// Requester, response and LU-side bus of the logic-unit arbiter.
interface logic_unit_arbiter_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic [2:0]   req1_op;
    logic         resp0_valid;
    logic         resp1_valid;
    logic [W-1:0] resp_data;
    logic [W-1:0] lu_a;
    logic [W-1:0] lu_b;
    logic [2:0]   lu_op;
    logic [W-1:0] lu_out;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  lu_out,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data,
        output lu_a, lu_b, lu_op
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output lu_out,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data,
        input  lu_a, lu_b, lu_op
    );
endinterface

// File: rtl/logic_unit_arbiter_lu_tag_pipe.sv
// Shift register of {v,id} tags that tracks ops through the fixed-depth LU.
module logic_unit_arbiter_lu_tag_pipe
    import logic_unit_arbiter_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_v
);

    tag_t stg [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
        end else begin
            stg[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i] <= stg[i-1];
            end
        end
    end

    always_comb begin
        any_v = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_v = any_v | stg[i].v;
        end
    end

    assign tag_out = stg[DEPTH-1];

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin sharing of the pipelined logic unit between two requesters,
// with per-op tagging, result routing, flush and drain control.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int LU_LAT = LU_LAT_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_unit_arbiter_if.slave bus,
    input  logic                flush,
    input  logic                drain_req,
    output logic                drain_ack,
    output logic [CW-1:0]       inflight0,
    output logic [CW-1:0]       inflight1,
    output logic                busy
);

    state_e        state;
    state_e        state_nxt;
    logic          last_grant;
    logic          gnt_v;
    logic          gnt_id;
    logic          iss0;
    logic          iss1;
    logic          ret0;
    logic          ret1;
    logic          rv;
    logic          tag_any;
    tag_t          tag_in;
    tag_t          tag_out;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic [2:0]    sel_op;

    // Grant is gated by reset so every output is quiet while rst_n is low.
    always_comb begin
        gnt_v  = 1'b0;
        gnt_id = 1'b0;
        if (rst_n && state == RUN && !flush) begin
            unique case (1'b1)
                bus.req0_valid && bus.req1_valid: begin
                    gnt_v  = 1'b1;
                    gnt_id = ~last_grant;
                end
                bus.req0_valid && !bus.req1_valid: begin
                    gnt_v  = 1'b1;
                    gnt_id = 1'b0;
                end
                !bus.req0_valid && bus.req1_valid: begin
                    gnt_v  = 1'b1;
                    gnt_id = 1'b1;
                end
                default: begin
                    gnt_v  = 1'b0;
                    gnt_id = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        if (gnt_v) begin
            sel_a  = gnt_id ? bus.req1_a  : bus.req0_a;
            sel_b  = gnt_id ? bus.req1_b  : bus.req0_b;
            sel_op = gnt_id ? bus.req1_op : bus.req0_op;
        end
    end

    assign bus.req0_ready = gnt_v & ~gnt_id;
    assign bus.req1_ready = gnt_v & gnt_id;
    assign bus.lu_a       = sel_a;
    assign bus.lu_b       = sel_b;
    assign bus.lu_op      = sel_op;

    assign tag_in = '{v: gnt_v, id: gnt_id};

    logic_unit_arbiter_lu_tag_pipe #(
        .DEPTH (LU_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .any_v   (tag_any)
    );

    assign rv              = rst_n & tag_out.v & ~flush;
    assign bus.resp0_valid = rv & ~tag_out.id;
    assign bus.resp1_valid = rv & tag_out.id;
    assign bus.resp_data   = bus.lu_out;

    assign iss0 = gnt_v & ~gnt_id;
    assign iss1 = gnt_v & gnt_id;
    assign ret0 = tag_out.v & ~tag_out.id;
    assign ret1 = tag_out.v & tag_out.id;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + CW'(iss0) - CW'(ret0);
            cnt1 <= cnt1 + CW'(iss1) - CW'(ret1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (gnt_v) begin
            last_grant <= gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (drain_req) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_nxt = RUN;
                end else if (!tag_any) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (!drain_req) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign busy      = rst_n & tag_any;
    assign drain_ack = rst_n & (state == HALTED);
    assign inflight0 = rst_n ? cnt0 : '0;
    assign inflight1 = rst_n ? cnt1 : '0;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a 3-stage LU model.
module tb_logic_unit_arbiter;

    localparam logic [31:0] OPA = 32'hF0F0_F0F0;
    localparam logic [31:0] OPB = 32'h0FF0_0FF0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       drain_req;
    logic       drain_ack;
    logic [1:0] inflight0;
    logic [1:0] inflight1;
    logic       busy;
    int         vecs = 0;
    int         errs = 0;

    logic [31:0] p0 = '0;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;

    logic_unit_arbiter_if #(.W(32)) bus ();

    logic_unit_arbiter #(
        .W      (32),
        .LU_LAT (3),
        .CW     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .drain_req (drain_req),
        .drain_ack (drain_ack),
        .inflight0 (inflight0),
        .inflight1 (inflight1),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lu_fn(logic [31:0] a, logic [31:0] b,
                                          logic [2:0] op);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~(a ^ b);
            3'd6:    return a & ~b;
            default: return a;
        endcase
    endfunction

    // Hand-computed results for OPA/OPB.
    function automatic logic [31:0] exp_of(int op);
        case (op)
            0:       return 32'h00F0_00F0;
            1:       return 32'hFFF0_FFF0;
            2:       return 32'hFF00_FF00;
            3:       return 32'hFF0F_FF0F;
            4:       return 32'h000F_000F;
            5:       return 32'h00FF_00FF;
            6:       return 32'hF000_F000;
            default: return 32'hF0F0_F0F0;
        endcase
    endfunction

    always @(posedge clk) begin
        p0 <= lu_fn(bus.lu_a, bus.lu_b, bus.lu_op);
        p1 <= p0;
        p2 <= p1;
    end
    assign bus.lu_out = p2;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a     = OPA;
        bus.req0_b     = OPB;
        bus.req1_a     = OPA;
        bus.req1_b     = OPB;
        bus.req0_op    = 3'd0;
        bus.req1_op    = 3'd0;
        flush          = 1'b0;
        drain_req      = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_op    = 3'd2;
        bus.req1_op    = 3'd5;
        rst_n          = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            @(negedge clk);
            vecs++;
            if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                errs++;
                $display("FAIL reset_ready k=%0d got %b%b exp 00",
                         k, bus.req0_ready, bus.req1_ready);
            end
            vecs++;
            if (busy !== 1'b0 || drain_ack !== 1'b0 || bus.lu_op !== 3'd0) begin
                errs++;
                $display("FAIL reset_out k=%0d busy=%b ack=%b op=%0d exp 0",
                         k, busy, drain_ack, bus.lu_op);
            end
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_first_grant got %b%b exp 10",
                     bus.req0_ready, bus.req1_ready);
        end
        vecs++;
        if (bus.lu_op !== 3'd2 || inflight0 !== 2'd0) begin
            errs++;
            $display("FAIL reset_issue op=%0d inf0=%0d exp op=2 inf0=0",
                     bus.lu_op, inflight0);
        end
        step();
        idle();
    endtask

    task automatic test_contention();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            if (k < 6) begin
                bus.req0_valid = 1'b1;
                bus.req1_valid = 1'b1;
                bus.req0_op    = 3'(k);
                bus.req1_op    = 3'(k);
            end else begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            @(negedge clk);
            if (k < 6) begin
                vecs++;
                if (bus.req0_ready !== (k % 2 == 0) ||
                    bus.req1_ready !== (k % 2 == 1)) begin
                    errs++;
                    $display("FAIL cont_grant k=%0d got %b%b exp r0=%b",
                             k, bus.req0_ready, bus.req1_ready, (k % 2 == 0));
                end
                vecs++;
                if (bus.lu_op !== 3'(k) || bus.lu_a !== OPA) begin
                    errs++;
                    $display("FAIL cont_issue k=%0d op=%0d a=%h exp op=%0d",
                             k, bus.lu_op, bus.lu_a, k);
                end
            end
            if (k >= 3) begin
                vecs++;
                if (bus.resp0_valid !== ((k - 3) % 2 == 0) ||
                    bus.resp1_valid !== ((k - 3) % 2 == 1)) begin
                    errs++;
                    $display("FAIL cont_resp k=%0d got %b%b exp r0=%b",
                             k, bus.resp0_valid, bus.resp1_valid,
                             ((k - 3) % 2 == 0));
                end
                vecs++;
                if (bus.resp_data !== exp_of(k - 3)) begin
                    errs++;
                    $display("FAIL cont_data k=%0d got %h exp %h",
                             k, bus.resp_data, exp_of(k - 3));
                end
            end else begin
                vecs++;
                if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL cont_early_resp k=%0d got %b%b exp 00",
                             k, bus.resp0_valid, bus.resp1_valid);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_single();
        logic [1:0] inf_exp [8] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                    2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus.req1_valid = (k < 4);
            bus.req1_op    = 3'(k);
            @(negedge clk);
            if (k < 4) begin
                vecs++;
                if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL single_grant k=%0d got %b%b exp 01",
                             k, bus.req0_ready, bus.req1_ready);
                end
            end
            vecs++;
            if (inflight1 !== inf_exp[k]) begin
                errs++;
                $display("FAIL single_inflight k=%0d got %0d exp %0d",
                         k, inflight1, inf_exp[k]);
            end
            vecs++;
            if (bus.resp1_valid !== (k >= 3 && k <= 6) ||
                bus.resp0_valid !== 1'b0) begin
                errs++;
                $display("FAIL single_resp k=%0d got %b%b", k,
                         bus.resp0_valid, bus.resp1_valid);
            end
            if (k >= 3 && k <= 6) begin
                vecs++;
                if (bus.resp_data !== exp_of(k - 3)) begin
                    errs++;
                    $display("FAIL single_data k=%0d got %h exp %h",
                             k, bus.resp_data, exp_of(k - 3));
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            bus.req0_valid = (k < 4);
            bus.req0_op    = 3'(k);
            flush          = (k == 3);
            @(negedge clk);
            if (k < 3) begin
                vecs++;
                if (bus.req0_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL flush_issue k=%0d got %b exp 1",
                             k, bus.req0_ready);
                end
            end else if (k == 3) begin
                vecs++;
                if (bus.req0_ready !== 1'b0 || bus.lu_a !== 32'h0) begin
                    errs++;
                    $display("FAIL flush_block got rdy=%b a=%h exp 0",
                             bus.req0_ready, bus.lu_a);
                end
            end else begin
                vecs++;
                if (busy !== 1'b0 || inflight0 !== 2'd0) begin
                    errs++;
                    $display("FAIL flush_clear k=%0d busy=%b inf0=%0d exp 0",
                             k, busy, inflight0);
                end
            end
            if (k >= 3) begin
                vecs++;
                if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL flush_resp k=%0d got %b%b exp 00",
                             k, bus.resp0_valid, bus.resp1_valid);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_drain();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bus.req0_valid = (k == 0) || (k >= 3);
            bus.req1_valid = (k == 1) || (k >= 3);
            bus.req0_op    = 3'd2;
            bus.req1_op    = 3'd3;
            drain_req      = (k >= 2 && k <= 6);
            @(negedge clk);
            if (k >= 3 && k <= 7) begin
                vecs++;
                if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                    errs++;
                    $display("FAIL drain_ready k=%0d got %b%b exp 00",
                             k, bus.req0_ready, bus.req1_ready);
                end
                vecs++;
                if (drain_ack !== (k >= 6)) begin
                    errs++;
                    $display("FAIL drain_ack k=%0d got %b exp %b",
                             k, drain_ack, (k >= 6));
                end
                vecs++;
                if (busy !== (k <= 4)) begin
                    errs++;
                    $display("FAIL drain_busy k=%0d got %b exp %b",
                             k, busy, (k <= 4));
                end
            end
            if (k == 3) begin
                vecs++;
                if (bus.resp0_valid !== 1'b1 || bus.resp_data !== exp_of(2)) begin
                    errs++;
                    $display("FAIL drain_resp0 got v=%b d=%h exp v=1 d=%h",
                             bus.resp0_valid, bus.resp_data, exp_of(2));
                end
            end
            if (k == 4) begin
                vecs++;
                if (bus.resp1_valid !== 1'b1 || bus.resp_data !== exp_of(3)) begin
                    errs++;
                    $display("FAIL drain_resp1 got v=%b d=%h exp v=1 d=%h",
                             bus.resp1_valid, bus.resp_data, exp_of(3));
                end
            end
            if (k == 8) begin
                vecs++;
                if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0 ||
                    drain_ack !== 1'b0) begin
                    errs++;
                    $display("FAIL drain_resume got %b%b ack=%b exp 10 ack=0",
                             bus.req0_ready, bus.req1_ready, drain_ack);
                end
            end
            step();
        end
        idle();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            bus.req0_valid = (k < 3);
            bus.req0_op    = 3'(k);
            rst_n          = (k != 3);
            @(negedge clk);
            if (k >= 3) begin
                vecs++;
                if (bus.resp0_valid !== 1'b0 || bus.resp1_valid !== 1'b0) begin
                    errs++;
                    $display("FAIL rstmid_resp k=%0d got %b%b exp 00",
                             k, bus.resp0_valid, bus.resp1_valid);
                end
                vecs++;
                if (busy !== 1'b0 || inflight0 !== 2'd0 || inflight1 !== 2'd0) begin
                    errs++;
                    $display("FAIL rstmid_cnt k=%0d busy=%b inf=%0d/%0d exp 0",
                             k, busy, inflight0, inflight1);
                end
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_contention();
        test_single();
        test_flush();
        test_drain();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
